// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns imem, PC and program-load port, sequences IDLE -> RUN -> HALTED.
// Optional single-step issue gating is enabled by defining INST_FETCH_STEP_MODE_EN (adds the step port).
module inst_fetch_unit #(
    parameter int                 ADDR_W    = 5,
    parameter int                 INST_W    = 16,
    parameter logic [INST_W-1:0]  IDLE_INST = 16'hE000,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic              run,
`ifdef INST_FETCH_STEP_MODE_EN
    input  logic              step,
`endif
    input  logic [ADDR_W-1:0] next_inst_addr,
    input  logic              pc_branch,
    input  logic              halt,
    output logic [ADDR_W-1:0] curr_inst_addr,
    output logic [INST_W-1:0] curr_inst,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  branch_count
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    logic [INST_W-1:0] imem [DEPTH];
    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              done_reg;
    logic [CNT_W-1:0]  inst_count_reg;
    logic [CNT_W-1:0]  branch_count_reg;

    logic step_ok;
    logic issue;
    logic load_fire;
    logic start;

`ifdef INST_FETCH_STEP_MODE_EN
    logic step_q_reg;

    // Edges seen outside RUN are dropped simply because issue also needs RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q_reg <= 1'b0;
        end else begin
            step_q_reg <= step;
        end
    end

    assign step_ok = step && !step_q_reg;
`else
    assign step_ok = 1'b1;
`endif

    assign load_ready = (state_reg != S_RUN);
    assign load_fire  = load_valid && load_ready;
    assign start      = run && !load_fire && (state_reg != S_RUN);
    assign issue      = (state_reg == S_RUN) && step_ok;

    // Contents survive reset; only the write itself is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && load_fire) begin
            imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            pc_reg           <= '0;
            done_reg         <= 1'b0;
            inst_count_reg   <= '0;
            branch_count_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_RUN: begin
                    if (issue) begin
                        pc_reg <= next_inst_addr;
                        if (inst_count_reg != CNT_MAX) begin
                            inst_count_reg <= inst_count_reg + CNT_W'(1);
                        end
                        if (pc_branch && (branch_count_reg != CNT_MAX)) begin
                            branch_count_reg <= branch_count_reg + CNT_W'(1);
                        end
                        // The halt word itself retires; pc keeps pointing at it.
                        if (halt) begin
                            state_reg <= S_HALTED;
                            pc_reg    <= pc_reg;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_reg        <= S_RUN;
                        pc_reg           <= '0;
                        inst_count_reg   <= '0;
                        branch_count_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign curr_inst_addr = pc_reg;
    assign curr_inst      = issue ? imem[pc_reg] : IDLE_INST;
    assign running        = (state_reg == S_RUN);
    assign done           = done_reg;
    assign inst_count     = inst_count_reg;
    assign branch_count   = branch_count_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (memory array, run/halt status, saturating counts).
module tb_inst_fetch_unit;

    localparam int ADDR_W = 5;
    localparam int INST_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [INST_W-1:0] load_data;
    logic              run;
    logic              step;
    logic [ADDR_W-1:0] next_inst_addr;
    logic              pc_branch;
    logic              halt;
    logic [ADDR_W-1:0] curr_inst_addr;
    logic [INST_W-1:0] curr_inst;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  branch_count;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .IDLE_INST(16'hE000), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .run            (run),
`ifdef INST_FETCH_STEP_MODE_EN
        .step           (step),
`endif
        .next_inst_addr (next_inst_addr),
        .pc_branch      (pc_branch),
        .halt           (halt),
        .curr_inst_addr (curr_inst_addr),
        .curr_inst      (curr_inst),
        .running        (running),
        .done           (done),
        .inst_count     (inst_count),
        .branch_count   (branch_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_state;
    int          m_pc;
    logic [15:0] m_mem [32];
    int          m_ic;
    int          m_bc;
    bit          m_done;
    bit          m_stepq;
    bit          auto_step;

    function automatic bit m_issue();
`ifdef INST_FETCH_STEP_MODE_EN
        return (m_state == 1) && step && !m_stepq;
`else
        return (m_state == 1);
`endif
    endfunction

    function automatic logic [15:0] m_inst();
        return m_issue() ? m_mem[m_pc] : 16'hE000;
    endfunction

    function automatic logic [15:0] rand_word(bit allow_halt);
        logic [15:0] w;
        w = 16'($urandom);
        if (!allow_halt && w[15:13] == 3'b111) w[15] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit fire;
        bit iss;
        iss  = m_issue();
        fire = load_valid && (m_state != 1);
        if (reset) begin
            m_state = 0; m_pc = 0; m_done = 0; m_ic = 0; m_bc = 0; m_stepq = 0;
            return;
        end
        m_done = 0;
        if (fire) m_mem[load_addr] = load_data;
        if (m_state == 1) begin
            if (iss) begin
                if (m_ic < CMAX) m_ic++;
                if (pc_branch && m_bc < CMAX) m_bc++;
                if (halt) begin
                    m_state = 2;
                    m_done  = 1;
                end else begin
                    m_pc = int'(next_inst_addr);
                end
            end
        end else if (run && !fire) begin
            m_state = 1; m_pc = 0; m_ic = 0; m_bc = 0;
        end
        m_stepq = step;
    endtask

    // One clock: core reacts to the word it is shown, outputs checked, then edge and model update.
    task automatic cycle();
        logic [15:0] ei;
        if (auto_step) step = !step;
        ei   = m_inst();
        halt = (ei[15:13] == 3'b111);
        #1;
        chk("load_ready",     32'(load_ready),     32'(m_state != 1));
        chk("curr_inst",      32'(curr_inst),      32'(ei));
        chk("curr_inst_addr", 32'(curr_inst_addr), 32'(m_pc));
        chk("running",        32'(running),        32'(m_state == 1));
        chk("done",           32'(done),           32'(m_done));
        chk("inst_count",     32'(inst_count),     32'(m_ic));
        chk("branch_count",   32'(branch_count),   32'(m_bc));
        $display("cyc %0d st=%0d pc=%0d inst=%h ic=%0d bc=%0d lv=%0b run=%0b rst=%0b",
                 cyc, m_state, m_pc, ei, m_ic, m_bc, load_valid, run, reset);
        cyc++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 0; load_valid = 0; run = 0; pc_branch = 0;
        next_inst_addr = 5'(m_pc + 1);
    endtask

    task automatic load(input int a, input logic [15:0] d);
        quiet();
        load_valid = 1; load_addr = 5'(a); load_data = d;
        cycle();
        load_valid = 0;
    endtask

    task automatic start_run();
        quiet();
        run = 1;
        cycle();
        run = 0;
    endtask

    task automatic run_until_halt(input int bound);
        int n;
        n = 0;
        while (m_state == 1 && n < bound) begin
            quiet();
            cycle();
            n++;
        end
        chk("halt_within_bound", 32'(m_state), 32'd2);
    endtask

    initial begin
        int dones;
        int prev_pc;
        bit wrapped;
        reset = 1; load_valid = 0; load_addr = '0; load_data = '0; run = 0; step = 0;
        next_inst_addr = '0; pc_branch = 0; halt = 0; auto_step = 1; m_stepq = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        model_update();
        @(negedge clk);
        quiet();
        cycle();
        chk("reset_state", 32'(running), 32'd0);

        for (int i = 0; i < 32; i++) load(i, rand_word(0));

        // Short program ending in a halt word
        load(0, 16'h2001); load(1, 16'h2002); load(2, 16'hE000);
        start_run();
        dones = 0;
        for (int n = 0; n < 20 && m_state != 2; n++) begin
            quiet();
            cycle();
            if (done) dones++;
        end
        quiet(); cycle();
        if (done) dones++;
        chk("t2_done_pulses", 32'(dones), 32'd1);
        chk("t2_inst_count",  32'(inst_count), 32'd3);
        chk("t2_pc_holds",    32'(curr_inst_addr), 32'd2);

        // Loads are refused while running; load+run together writes and stays put
        start_run();
        quiet(); load_valid = 1; load_addr = 5'd5; load_data = 16'h1234;
        cycle();
        chk("t3_ready_in_run", 32'(load_ready), 32'd0);
        run_until_halt(20);
        quiet(); load_valid = 1; run = 1; load_addr = 5'd6; load_data = 16'h0BAD;
        cycle();
        quiet(); cycle();
        chk("t3_load_run_no_start", 32'(running), 32'd0);

        // Jump to 31, wrap to 0, branch on four issues, then halt at 2
        load(31, 16'h1111);
        start_run();
        wrapped = 0;
        for (int n = 0; n < 20 && m_state == 1; n++) begin
            quiet();
            next_inst_addr = (m_pc == 0 && !wrapped) ? 5'd31 : 5'(m_pc + 1);
            pc_branch = (m_pc != 2);
            prev_pc = m_pc;
            cycle();
            if (prev_pc == 31 && m_pc == 0) begin
                wrapped = 1;
                chk("t4_wrap_pc", 32'(curr_inst_addr), 32'd0);
            end
        end
        chk("t4_branch_count", 32'(branch_count), 32'd4);
        chk("t4_inst_count",   32'(inst_count),   32'd5);

        // Saturation over a halt-free loop, then reset mid-run
        load(2, 16'h2003);
        start_run();
        for (int n = 0; n < 44; n++) begin
            quiet();
            next_inst_addr = 5'((m_pc + 1) % 8);
            cycle();
        end
        chk("t5_saturated", 32'(inst_count), 32'd15);
        quiet(); reset = 1;
        cycle();
        quiet(); cycle();
        chk("t1_reset_pc",      32'(curr_inst_addr), 32'd0);
        chk("t1_reset_running", 32'(running),        32'd0);
        chk("t1_reset_count",   32'(inst_count),     32'd0);
        chk("t1_reset_done",    32'(done),           32'd0);

`ifdef INST_FETCH_STEP_MODE_EN
        auto_step = 0; step = 0;
        start_run();
        step = 1;
        for (int n = 0; n < 10; n++) begin quiet(); cycle(); end
        chk("t6_held_step_one_issue", 32'(inst_count), 32'd1);
        for (int p = 0; p < 3; p++) begin
            step = 0; quiet(); cycle();
            step = 1; quiet(); cycle();
        end
        step = 0; quiet(); cycle();
        chk("t6_three_pulses_pc", 32'(curr_inst_addr), 32'd4);
        chk("t6_idle_no_halt",    32'(running),        32'd1);
        auto_step = 1;
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 49) == 0);
            load_valid     = ($urandom_range(0, 3) == 0);
            load_addr      = 5'($urandom);
            load_data      = rand_word($urandom_range(0, 7) == 0);
            run            = ($urandom_range(0, 4) == 0);
            next_inst_addr = ($urandom_range(0, 1) == 0) ? 5'(m_pc + 1) : 5'($urandom);
            pc_branch      = 1'($urandom);
            if ($urandom_range(0, 3) == 0) auto_step = !auto_step;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
